instr_fetch: RTL and testbench

Instruction fetch stage of the single-cycle MIPS datapath. It holds the program counter and issues word reads to instruction memory over a request/ready handshake. It presents each fetched 32-bit instruction word with its PC to the field decoder and execute logic, and waits for an acknowledge. On acknowledge it computes the next PC from the redirect inputs (sequential, branch, jump, jump-register) for the instruction being retired.

---
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a req/ready
// handshake, presents the word until acknowledged, then redirects the PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    input  logic        br_taken,
    input  logic [15:0] br_imm16,
    input  logic        jump,
    input  logic [25:0] jump_imm26,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] icount
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic        [31:0] pc;
    logic        [31:0] next_pc;
    logic signed [31:0] br_off;

    // Handshake outputs decode straight from registered state; no input-to-output path.
    assign imem_req   = (state == FETCH);
    assign inst_valid = (state == HOLD);
    assign imem_addr  = pc;
    assign pc_plus4   = inst_pc + 32'd4;

    assign br_off = {{14{br_imm16[15]}}, br_imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_imm26, 2'b00};
        end else if (br_taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= 32'd0;
            inst_pc     <= 32'd0;
            fetch_err   <= 1'b0;
            icount      <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instruction <= imem_rdata;
                        inst_pc     <= pc;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ack) begin
                        pc     <= next_pc;
                        icount <= icount + 32'd1;
                        state  <= FETCH;
                        // A misaligned register target is truncated but remembered.
                        if (jr && (jr_target[1:0] != 2'b00)) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_imm16 = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_imm26 = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic [31:0] icount;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .instruction(instruction),
        .inst_pc    (inst_pc),
        .inst_ack   (inst_ack),
        .br_taken   (br_taken),
        .br_imm16   (br_imm16),
        .jump       (jump),
        .jump_imm26 (jump_imm26),
        .jr         (jr),
        .jr_target  (jr_target),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err),
        .icount     (icount)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_pc, m_icount, m_inst, m_ipc;
    logic        m_err;

    typedef struct {
        int          wt;
        int          st;
        logic [31:0] word;
        logic        br;
        logic [15:0] imm16;
        logic        j;
        logic [25:0] imm26;
        logic        jrr;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] ipc, input logic b,
                                             input logic [15:0] i16, input logic jj,
                                             input logic [25:0] i26, input logic r,
                                             input logic [31:0] t);
        logic [31:0] pp4;
        int          off;
        pp4 = ipc + 32'd4;
        if (r) return t - (t % 4);
        if (jj) return (pp4 & 32'hF000_0000) + ({6'd0, i26} * 32'd4);
        if (b) begin
            off = $signed(i16);
            return pp4 + 32'(off * 4);
        end
        return pp4;
    endfunction

    task automatic chk_fetch_state(input string tag);
        chk({tag, "_req"}, imem_req, 1'b1);
        chk({tag, "_valid"}, inst_valid, 1'b0);
        chk({tag, "_addr"}, imem_addr, m_pc);
    endtask

    task automatic chk_hold_state(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_valid"}, inst_valid, 1'b1);
        chk({tag, "_inst"}, instruction, m_inst);
        chk({tag, "_ipc"}, inst_pc, m_ipc);
        chk({tag, "_pp4"}, pc_plus4, m_ipc + 32'd4);
        chk({tag, "_icount"}, icount, m_icount);
        chk({tag, "_err"}, fetch_err, m_err);
    endtask

    task automatic do_fetch(input int wt, input logic [31:0] word);
        repeat (wt) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            inst_ack   = 1'($urandom_range(0, 1));
            step();
            chk_fetch_state("wait");
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        inst_ack   = 1'($urandom_range(0, 1));
        step();
        imem_ready = 1'b0;
        inst_ack   = 1'b0;
        m_inst = word;
        m_ipc  = m_pc;
        chk_hold_state("capture");
    endtask

    task automatic do_ack(input int st, input logic b, input logic [15:0] i16,
                          input logic jj, input logic [25:0] i26, input logic r,
                          input logic [31:0] t);
        repeat (st) begin
            inst_ack   = 1'b0;
            imem_ready = 1'($urandom_range(0, 1));
            br_taken   = 1'($urandom_range(0, 1));
            jump       = 1'($urandom_range(0, 1));
            jr         = 1'($urandom_range(0, 1));
            jr_target  = $urandom | 32'd1;
            br_imm16   = 16'($urandom);
            jump_imm26 = 26'($urandom);
            step();
            chk_hold_state("stall");
        end
        imem_ready = 1'b0;
        inst_ack   = 1'b1;
        br_taken   = b;
        br_imm16   = i16;
        jump       = jj;
        jump_imm26 = i26;
        jr         = r;
        jr_target  = t;
        step();
        inst_ack = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        jr       = 1'b0;
        m_pc     = ref_next(m_ipc, b, i16, jj, i26, r, t);
        m_icount = m_icount + 32'd1;
        if (r && (t % 4) != 0) m_err = 1'b1;
        chk_fetch_state("ack");
        chk("ack_icount", icount, m_icount);
        chk("ack_err", fetch_err, m_err);
    endtask

    // Entered at posedge+1; asserts reset between edges and leaves at posedge+1.
    task automatic do_reset();
        #3;
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        inst_ack   = 1'b1;
        #1;
        m_pc = RESET_PC; m_icount = 0; m_inst = 0; m_ipc = 0; m_err = 0;
        chk("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", instruction, 32'd0);
        chk("rst_ipc", inst_pc, 32'd0);
        chk("rst_err", fetch_err, 1'b0);
        chk("rst_icount", icount, 32'd0);
        step();
        chk("rst_edge_valid", inst_valid, 1'b0);
        chk("rst_edge_inst", instruction, 32'd0);
        #2;
        reset      = 1'b0;
        imem_ready = 1'b0;
        inst_ack   = 1'b0;
        #1;
        chk_fetch_state("post_rst");
        step();
        chk_fetch_state("post_rst2");
        chk("post_rst_icount", icount, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        wt st word           br imm16     j  imm26          jr tgt            exp_addr       err
        vt[0]  = '{0, 0, 32'h2001_0001, 0, 16'h0000, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_0004, 0};
        vt[1]  = '{0, 0, 32'h2002_0002, 0, 16'h0000, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_0008, 0};
        vt[2]  = '{3, 0, 32'h2402_0005, 0, 16'h0000, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_000C, 0};
        vt[3]  = '{0, 4, 32'h0000_0020, 0, 16'h0000, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_0010, 0};
        vt[4]  = '{0, 0, 32'h0800_0040, 0, 16'h0000, 1, 26'h000_0040, 0, 32'h0000_0000, 32'h0000_0100, 0};
        vt[5]  = '{1, 0, 32'h1000_FFFE, 1, 16'hFFFE, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_00FC, 0};
        vt[6]  = '{0, 1, 32'h0800_0040, 0, 16'h0000, 1, 26'h000_0040, 0, 32'h0000_0000, 32'h0000_0100, 0};
        vt[7]  = '{0, 0, 32'h1000_0003, 1, 16'h0003, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_0110, 0};
        vt[8]  = '{0, 0, 32'h0380_0008, 0, 16'h0000, 0, 26'h000_0000, 1, 32'h4000_0010, 32'h4000_0010, 0};
        vt[9]  = '{0, 0, 32'h0800_0040, 0, 16'h0000, 1, 26'h000_0040, 0, 32'h0000_0000, 32'h4000_0100, 0};
        vt[10] = '{0, 2, 32'h0060_0009, 1, 16'h0100, 1, 26'h3FF_FFFF, 1, 32'h0000_2003, 32'h0000_2000, 1};
        vt[11] = '{0, 0, 32'h1000_0010, 1, 16'h0010, 0, 26'h000_0000, 0, 32'h0000_0000, 32'h0000_2044, 1};
        vt[12] = '{0, 0, 32'h2003_0003, 0, 16'h0000, 0, 26'h000_0000, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1};

        step();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            do_fetch(vt[i].wt, vt[i].word);
            do_ack(vt[i].st, vt[i].br, vt[i].imm16, vt[i].j, vt[i].imm26, vt[i].jrr, vt[i].tgt);
            chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].exp_addr);
            chk($sformatf("tbl%0d_err", i), fetch_err, vt[i].exp_err);
            chk($sformatf("tbl%0d_icount", i), icount, 32'(i + 1));
        end

        // PC wrap at the top of the address space
        do_fetch(0, 32'h0000_0000);
        chk("wrap_pp4", pc_plus4, 32'h0000_0000);
        do_ack(0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_err_sticky", fetch_err, 1'b1);

        // Reset mid-FETCH clears sticky error and count
        do_reset();

        // Build up to inst_pc=0x20, icount=5, then reset mid-HOLD
        for (int i = 0; i < 4; i++) begin
            do_fetch(0, 32'h2000_0000 + 32'(i));
            do_ack(0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        end
        do_fetch(0, 32'h1000_0003);
        do_ack(0, 1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0);
        chk("pre_rst_addr", imem_addr, 32'h0000_0020);
        do_fetch(1, 32'hDEAD_BEEF);
        chk("pre_rst_ipc", inst_pc, 32'h0000_0020);
        chk("pre_rst_icount", icount, 32'd5);
        do_reset();

        // Randomized transactions against the reference model
        for (int k = 0; k < 60; k++) begin
            do_fetch(int'($urandom_range(0, 2)), $urandom);
            do_ack(int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 16'($urandom),
                   ($urandom_range(0, 3) == 0), 26'($urandom),
                   ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
